// File: rtl/mem_except_unit.sv
// Memory exception unit: per-access misalign, access-range and data-watchpoint
// detection, plus a one-deep capture of the highest-priority exception that
// holds until the trap handler acknowledges it.
module mem_except_unit #(
    parameter int          N         = 64,
    parameter int          NWP       = 2,
    parameter logic [N-1:0] ACC_BASE  = '0,
    parameter logic [N-1:0] ACC_LIMIT = N'(64'h0000_0000_0000_FFFF)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_i,
    input  logic [N-1:0] DM_addr,
    input  logic [1:0]   memOp,
    input  logic [2:0]   memWidth,
    input  logic         wp_we,
    input  logic [1:0]   wp_idx,
    input  logic [N-1:0] wp_addr,
    input  logic [1:0]   wp_mode,
    input  logic         except_ack,
    output logic         mem_kill,
    output logic [6:0]   exceptSignal,
    output logic         except_pending,
    output logic [2:0]   except_cause,
    output logic [N-1:0] except_tval,
    output logic         except_lost,
    output logic [15:0]  except_count
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    logic [0:0]              state;
    logic [NWP-1:0][N-1:3]   wp_a;
    logic [NWP-1:0][1:0]     wp_m;

    // A simultaneous read+write op counts as a write only.
    logic is_wr, is_rd;
    assign is_wr = memOp[1];
    assign is_rd = memOp[0] & ~memOp[1];

    // Footprint of the access within a doubleword; anything spilling into
    // bit 8 crosses the doubleword boundary.
    logic [8:0] wmask;
    logic       misal;
    assign wmask = {1'b0, {4{memWidth[2]}}, {2{memWidth[1]}}, memWidth[0], 1'b1} << DM_addr[2:0];
    assign misal = wmask[8];

    // Lower bound check is dropped entirely when the legal range starts at 0.
    logic below, above, acc_fault;
    generate
        if (ACC_BASE == '0) begin : g_nobase
            assign below = 1'b0;
        end else begin : g_base
            assign below = DM_addr < ACC_BASE;
        end
    endgenerate
    assign above     = DM_addr > ACC_LIMIT;
    assign acc_fault = below | above;

    // Watchpoint compare at doubleword granularity against the current entries.
    logic hit;
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NWP; i++) begin
            if (((wp_m[i][0] & is_rd) | (wp_m[i][1] & is_wr)) && (DM_addr[N-1:3] == wp_a[i]))
                hit = 1'b1;
        end
    end

    assign exceptSignal[0] = valid_i & is_rd & misal;
    assign exceptSignal[1] = valid_i & is_rd & acc_fault;
    assign exceptSignal[2] = valid_i & is_wr & misal;
    assign exceptSignal[3] = valid_i & is_wr & acc_fault;
    assign exceptSignal[4] = 1'b0;
    assign exceptSignal[5] = 1'b0;
    assign exceptSignal[6] = valid_i & hit;
    assign mem_kill        = |exceptSignal;

    // Cause selection: breakpoint beats misalign beats access fault.
    logic [2:0] cause_nx;
    always_comb begin
        cause_nx = 3'd0;
        if      (exceptSignal[6]) cause_nx = 3'd7;
        else if (exceptSignal[0]) cause_nx = 3'd1;
        else if (exceptSignal[2]) cause_nx = 3'd3;
        else if (exceptSignal[1]) cause_nx = 3'd2;
        else if (exceptSignal[3]) cause_nx = 3'd4;
    end

    // Watchpoint table; out-of-range indices write nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_a <= '0;
            wp_m <= '0;
        end else begin
            for (int i = 0; i < NWP; i++) begin
                if (wp_we && wp_idx == 2'(i)) begin
                    wp_a[i] <= wp_addr[N-1:3];
                    wp_m[i] <= wp_mode;
                end
            end
        end
    end

    // Capture FSM: take an exception in IDLE, hold it in PENDING until ack;
    // an ack coinciding with a new exception hands straight over to it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            except_cause <= '0;
            except_tval  <= '0;
            except_lost  <= 1'b0;
            except_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_kill) begin
                        state        <= PENDING;
                        except_cause <= cause_nx;
                        except_tval  <= DM_addr;
                        if (except_count != 16'hFFFF) except_count <= except_count + 16'd1;
                    end
                end
                default: begin
                    if (except_ack) begin
                        except_lost <= 1'b0;
                        if (mem_kill) begin
                            except_cause <= cause_nx;
                            except_tval  <= DM_addr;
                            if (except_count != 16'hFFFF) except_count <= except_count + 16'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (mem_kill) begin
                        except_lost <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign except_pending = (state == PENDING);

endmodule

// File: tb/tb_mem_except_unit.sv
// Self-checking bench for mem_except_unit: combinational exception bits are
// checked directly, captured state goes through an expectation queue.
module tb_mem_except_unit;

    logic        clk = 1'b0;
    logic        reset, valid_i, wp_we, except_ack;
    logic [63:0] DM_addr, wp_addr;
    logic [1:0]  memOp, wp_idx, wp_mode;
    logic [2:0]  memWidth;
    logic        mem_kill, except_pending, except_lost;
    logic [6:0]  exceptSignal;
    logic [2:0]  except_cause;
    logic [63:0] except_tval;
    logic [15:0] except_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic        pend;
        logic [2:0]  cause;
        logic [63:0] tval;
        logic        lost;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb[$];

    mem_except_unit dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .DM_addr(DM_addr),
        .memOp(memOp), .memWidth(memWidth), .wp_we(wp_we), .wp_idx(wp_idx),
        .wp_addr(wp_addr), .wp_mode(wp_mode), .except_ack(except_ack),
        .mem_kill(mem_kill), .exceptSignal(exceptSignal),
        .except_pending(except_pending), .except_cause(except_cause),
        .except_tval(except_tval), .except_lost(except_lost),
        .except_count(except_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic p, input logic [2:0] c,
                        input logic [63:0] t, input logic l, input logic [15:0] n);
        exp_t e;
        e.tag = tag; e.pend = p; e.cause = c; e.tval = t; e.lost = l; e.cnt = n;
        sb.push_back(e);
    endtask

    task automatic pop_chk();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".pend"},  64'(except_pending), 64'(e.pend));
        chk({e.tag, ".cause"}, 64'(except_cause),   64'(e.cause));
        chk({e.tag, ".tval"},  except_tval,         e.tval);
        chk({e.tag, ".lost"},  64'(except_lost),    64'(e.lost));
        chk({e.tag, ".cnt"},   64'(except_count),   64'(e.cnt));
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] mw,
                         input logic [63:0] a);
        valid_i = v; memOp = op; memWidth = mw; DM_addr = a;
    endtask

    // Present an access for a fraction of a cycle only, so nothing is captured.
    task automatic comb_chk(input string tag, input logic [1:0] op, input logic [2:0] mw,
                            input logic [63:0] a, input logic [6:0] exp);
        drive(1'b1, op, mw, a);
        #1;
        chk({tag, ".exc"},  64'(exceptSignal), 64'(exp));
        chk({tag, ".kill"}, 64'(mem_kill),     64'(|exp));
        valid_i = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; valid_i = 1'b0; except_ack = 1'b0; wp_we = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic wp_write(input logic [1:0] idx, input logic [63:0] a, input logic [1:0] m);
        wp_we = 1'b1; wp_idx = idx; wp_addr = a; wp_mode = m;
        cyc();
        wp_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; valid_i = 1'b0; DM_addr = '0; memOp = '0; memWidth = '0;
        wp_we = 1'b0; wp_idx = '0; wp_addr = '0; wp_mode = '0; except_ack = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        push("reset", 0, 0, 0, 0, 0); pop_chk();
        chk("reset.exc", 64'(exceptSignal), 64'd0);

        // First fault: read word at 0x1006 crosses the doubleword.
        drive(1, 2'b01, 3'b011, 64'h1006);
        #1;
        chk("rdmis.exc", 64'(exceptSignal), 64'b0000001);
        chk("rdmis.kill", 64'(mem_kill), 64'd1);
        push("rdmis", 1, 1, 64'h1006, 0, 1);
        cyc(); valid_i = 1'b0; pop_chk();
        except_ack = 1'b1;
        push("ack_idle", 0, 1, 64'h1006, 0, 1);
        cyc(); except_ack = 1'b0; pop_chk();
        push("ack_in_idle", 0, 1, 64'h1006, 0, 1);
        except_ack = 1'b1; cyc(); except_ack = 1'b0; pop_chk();

        // Boundary and gating cases, never held across an edge.
        comb_chk("rd_ffff",   2'b01, 3'b000, 64'hFFFF,  7'b0000000);
        comb_chk("rd_10000",  2'b01, 3'b000, 64'h10000, 7'b0000010);
        comb_chk("rw_10000",  2'b11, 3'b000, 64'h10000, 7'b0001000);
        comb_chk("half_1",    2'b01, 3'b001, 64'h1,     7'b0000000);
        comb_chk("half_7",    2'b01, 3'b001, 64'h7,     7'b0000001);
        comb_chk("word_4",    2'b01, 3'b011, 64'h4,     7'b0000000);
        comb_chk("wr_dbl_101",2'b10, 3'b111, 64'h101,   7'b0000100);
        comb_chk("wr_both",   2'b10, 3'b111, 64'h10001, 7'b0001100);
        comb_chk("noop",      2'b00, 3'b111, 64'h10001, 7'b0000000);
        drive(0, 2'b01, 3'b111, 64'h10001); #1;
        chk("novalid.exc", 64'(exceptSignal), 64'd0);

        // Write access fault, then a second fault while pending.
        do_reset();
        drive(1, 2'b10, 3'b111, 64'h20000); #1;
        chk("wracc.exc", 64'(exceptSignal), 64'b0001000);
        push("wracc", 1, 4, 64'h20000, 0, 1);
        cyc(); pop_chk();
        push("wracc_lost", 1, 4, 64'h20000, 1, 1);
        cyc(); valid_i = 1'b0; pop_chk();
        except_ack = 1'b1;
        push("wracc_ack", 0, 4, 64'h20000, 0, 1);
        cyc(); except_ack = 1'b0; pop_chk();

        // Watchpoints: same-cycle write is not yet visible.
        do_reset();
        wp_we = 1'b1; wp_idx = 2'd0; wp_addr = 64'h1000; wp_mode = 2'b10;
        drive(1, 2'b10, 3'b000, 64'h1007); #1;
        chk("wp_samecyc.exc", 64'(exceptSignal), 64'd0);
        valid_i = 1'b0;
        cyc(); wp_we = 1'b0;
        comb_chk("wp_wr",  2'b10, 3'b000, 64'h1007, 7'b1000000);
        comb_chk("wp_rd",  2'b01, 3'b000, 64'h1007, 7'b0000000);
        comb_chk("wp_rw",  2'b11, 3'b000, 64'h1007, 7'b1000000);
        comb_chk("wp_nxt", 2'b10, 3'b000, 64'h1008, 7'b0000000);
        wp_write(2'd2, 64'h2000, 2'b11);
        comb_chk("wp_idx2", 2'b01, 3'b000, 64'h2000, 7'b0000000);
        drive(1, 2'b10, 3'b000, 64'h1007);
        push("bkpt", 1, 7, 64'h1007, 0, 1);
        cyc(); pop_chk();

        // Ack coincident with a new read misalign hands over without loss.
        except_ack = 1'b1; drive(1, 2'b01, 3'b111, 64'h3);
        push("ack_new", 1, 1, 64'h3, 0, 2);
        cyc(); except_ack = 1'b0; pop_chk();
        push("lost_set", 1, 1, 64'h3, 1, 2);
        cyc(); valid_i = 1'b0; pop_chk();
        push("lost_sticky", 1, 1, 64'h3, 1, 2);
        cyc(); pop_chk();
        except_ack = 1'b1;
        push("lost_clr", 0, 1, 64'h3, 0, 2);
        cyc(); except_ack = 1'b0; pop_chk();

        // Reset while pending with count 5 overrides access, ack and wp_we.
        do_reset();
        wp_write(2'd0, 64'h1000, 2'b11);
        except_ack = 1'b1; drive(1, 2'b01, 3'b111, 64'h3);
        repeat (5) cyc();
        push("pre_rst", 1, 1, 64'h3, 0, 5); pop_chk();
        reset = 1'b1; wp_we = 1'b1; wp_idx = 2'd1; wp_addr = 64'h3000; wp_mode = 2'b11;
        push("rst_pend", 0, 0, 64'h0, 0, 0);
        cyc();
        reset = 1'b0; wp_we = 1'b0; valid_i = 1'b0; except_ack = 1'b0;
        pop_chk();
        comb_chk("rst_wp0", 2'b01, 3'b000, 64'h1000, 7'b0000000);
        comb_chk("rst_wp1", 2'b01, 3'b000, 64'h3000, 7'b0000000);

        // Saturation: back-to-back faults with ack increment every cycle.
        do_reset();
        except_ack = 1'b1; drive(1, 2'b01, 3'b111, 64'h3);
        repeat (65534) cyc();
        push("sat_fffe", 1, 1, 64'h3, 0, 16'hFFFE); pop_chk();
        cyc();
        push("sat_ffff", 1, 1, 64'h3, 0, 16'hFFFF); pop_chk();
        repeat (3) cyc();
        push("sat_hold", 1, 1, 64'h3, 0, 16'hFFFF); pop_chk();
        except_ack = 1'b0;
        cyc();
        push("sat_lost", 1, 1, 64'h3, 1, 16'hFFFF); pop_chk();
        valid_i = 1'b0;

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_except_unit.md
MEM_EXCEPT_UNIT -- requirements
Module: mem_except_unit

Interface
REQ-001 SHALL have parameter N, default 64: address width.
REQ-002 SHALL have parameter NWP, default 2: number of data watchpoints (1..4).
REQ-003 SHALL have parameter ACC_BASE, default 0: lowest legal data address.
REQ-004 SHALL have parameter ACC_LIMIT, default 64'h0000_0000_0000_FFFF: highest legal data address, inclusive.
REQ-005 SHALL have clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have valid_i  in  1  a memory access is presented this cycle.
REQ-008 SHALL have DM_addr  in  N  access byte address.
REQ-009 SHALL have memOp  in  2  bit0 read, bit1 write; 2'b11 is treated as write only.
REQ-010 SHALL have memWidth  in  3  thermometer size: 000 byte, 001 half, 011 word, 111 double.
REQ-011 SHALL have wp_we  in  1  write one watchpoint entry.
REQ-012 SHALL have wp_idx  in  2  entry index; writes with wp_idx >= NWP are ignored.
REQ-013 SHALL have wp_addr  in  N  watch address (doubleword granular).
REQ-014 SHALL have wp_mode  in  2  00 off, 01 read, 10 write, 11 read+write.
REQ-015 SHALL have except_ack  in  1  trap handler has consumed the pending exception.
REQ-016 SHALL have mem_kill  out  1  combinational: suppress the current access.
REQ-017 SHALL have exceptSignal  out  7  combinational, {bkpt, wr page fault, rd page fault, wr access, wr misalign, rd access, rd misalign} (bit6..bit0).
REQ-018 SHALL have except_pending  out  1  a captured exception awaits acknowledge.
REQ-019 SHALL have except_cause  out  3  captured cause code.
REQ-020 SHALL have except_tval  out  N  captured faulting address.
REQ-021 SHALL have except_lost  out  1  sticky: an exception occurred while one was pending.
REQ-022 SHALL have except_count  out  16  saturating count of captured exceptions.

Function
REQ-023 Misalign: the width mask {memWidth[2]x4, memWidth[1]x2, memWidth[0], 1} shifted left by DM_addr[2:0] into 9 bits; bit8 set = misaligned.
REQ-024 Access fault: DM_addr < ACC_BASE or DM_addr > ACC_LIMIT, unsigned compare.
REQ-025 Watch hit: entry mode matches the access direction and DM_addr[N-1:3] == wp_addr[N-1:3].
REQ-026 exceptSignal bits SHALL be gated by valid_i; page-fault bits SHALL be constant 0.
REQ-027 mem_kill SHALL equal the OR of exceptSignal.
REQ-028 Cause priority SHALL be breakpoint(7) > misalign > access fault; codes: rd misalign 1, rd access 2, wr misalign 3, wr access 4, none 0.
REQ-029 FSM states SHALL be IDLE and PENDING; except_pending is 1 exactly in PENDING.
REQ-030 IDLE: any exceptSignal bit set -> latch cause and DM_addr, increment count, go to PENDING at the next edge.
REQ-031 PENDING: cause and tval SHALL hold; a new exception SHALL set except_lost and SHALL NOT change count or capture.
REQ-032 PENDING with except_ack and no exception -> IDLE next cycle; cause, tval retained.
REQ-033 PENDING with except_ack and a simultaneous exception -> capture the new one, stay PENDING, increment count, no lost.
REQ-034 except_ack in IDLE SHALL be ignored.
REQ-035 except_lost SHALL clear only on except_ack or reset.
REQ-036 except_count SHALL saturate at 16'hFFFF.
REQ-037 A watchpoint write SHALL take effect from the next cycle; same-cycle access uses the old entry.
REQ-038 Capture latency SHALL be 1 cycle from the faulting access to except_pending.

Reset
REQ-039 On reset: FSM to IDLE; except_pending 0, except_cause 0, except_tval 0, except_lost 0, except_count 0, all watchpoint modes 00.
REQ-040 Reset SHALL override simultaneous access, ack and wp_we; reset during PENDING drops the exception.

Verification
REQ-041 Read, memWidth=011, DM_addr=0x1006, valid -> exceptSignal=0000001, mem_kill=1, next cycle pending=1, cause=1, tval=0x1006, count=1.
REQ-042 Write, memWidth=111, DM_addr=0x20000 -> bit3 set, cause=4; then a second fault before ack -> except_lost=1, count stays 1.
REQ-043 wp0 = 0x1000, mode 10; write, byte, DM_addr=0x1007 -> bit6 set, cause=7; same access as read -> no exception.
REQ-044 PENDING, ack coincident with a read misalign at 0x3 -> stays PENDING, cause=1, tval=0x3, count incremented.
REQ-045 Reset asserted while PENDING with count=5 -> next cycle all outputs 0, watchpoints disabled.
REQ-046 Preload count near saturation via 65535 faults+acks -> count holds 16'hFFFF on further faults.
